seg_scan_ctrl: RTL

Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display. Holds a 32-bit value (8 hex nibbles) plus per-digit decimal-point and enable masks, cycles through the digits at a fixed refresh rate, and drives the active-low anode lines. It also drives the 4-bit digit code and an active-low decimal point. It sits directly upstream of the combinational nibble-to-segment decoder, which turns `NUM` into segment lines. Updates are double-buffered and committed only at frame boundaries, so the display never shows a half-written value.

---
 rtl/seg_scan_ctrl_pkg.sv | 21 ++
 rtl/seg_scan_ctrl_lz_mask.sv | 22 ++
 rtl/seg_scan_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, scan FSM encoding and buffer layout for the
// 8-digit 7-segment scan controller.
package seg_scan_ctrl_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] AN_OFF     = 8'hFF;
  localparam logic       DP_OFF     = 1'b1;

  typedef enum logic {
    SCAN_GUARD = 1'b0,
    SCAN_SHOW  = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   en;
    logic                    lz;
  } disp_buf_t;

endpackage

// File: rtl/seg_scan_ctrl_lz_mask.sv
// Leading-zero suppression: flags digit i when lz is set and nibbles 7..i
// are all zero. Digit 0 is never flagged so a zero value still shows "0".
module lz_mask
  import seg_scan_ctrl_pkg::*;
(
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic                    i_lz,
  output logic [NUM_DIGITS-1:0]   o_suppress
);

  logic w_zero;

  always_comb begin
    o_suppress = '0;
    w_zero     = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_zero        = w_zero & (i_data[4*i +: 4] == 4'h0);
      o_suppress[i] = i_lz & w_zero;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode display with
// double-buffered, frame-aligned updates and registered outputs.
//
//   state      | meaning
//   SCAN_GUARD | anti-ghost blank at slot start, all anodes off
//   SCAN_SHOW  | active digit lit if enabled and not suppressed
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DIV   = 100_000,
  parameter int GUARD = 1_000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]   i_dp_in,
  input  logic [NUM_DIGITS-1:0]   i_en,
  input  logic                    i_blank_lz,
  input  logic                    i_load,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [3:0]              o_num,
  output logic                    o_dp_n,
  output logic                    o_frame
);

  localparam int            CW         = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

  scan_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  disp_buf_t     r_pend, r_comm, w_in;

  logic [NUM_DIGITS-1:0] r_an, w_an_nxt;
  logic [3:0]            r_num, w_num_nxt;
  logic                  r_dp_n, w_dp_n_nxt;
  logic                  r_frame;

  logic                  w_wrap;
  logic                  w_lit;
  logic [3:0]            w_nib;
  logic [NUM_DIGITS-1:0] w_suppress;

  assign w_in = '{data: i_data, dp: i_dp_in, en: i_en, lz: i_blank_lz};

  lz_mask u_lz_mask (
    .i_data     (r_comm.data),
    .i_lz       (r_comm.lz),
    .o_suppress (w_suppress)
  );

  assign w_nib = r_comm.data[{r_idx, 2'b00} +: 4];
  assign w_lit = r_comm.en[r_idx] & ~w_suppress[r_idx];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_wrap      = 1'b0;
    w_an_nxt    = AN_OFF;
    w_num_nxt   = r_num;
    w_dp_n_nxt  = DP_OFF;
    case (r_state)
      SCAN_GUARD: begin
        if (r_cnt == GUARD_LAST) w_state_nxt = SCAN_SHOW;
      end
      SCAN_SHOW: begin
        w_num_nxt = w_nib;
        if (w_lit) begin
          w_an_nxt   = ~(NUM_DIGITS'(1) << r_idx);
          w_dp_n_nxt = ~r_comm.dp[r_idx];
        end
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 3'd1;
          w_state_nxt = SCAN_GUARD;
          w_wrap      = (r_idx == 3'd7);
        end
      end
      default: w_state_nxt = SCAN_GUARD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SCAN_GUARD;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // A LOAD landing on the wrap cycle bypasses pending so it is not lost for a frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= '0;
      r_comm <= '0;
    end else begin
      if (i_load) r_pend <= w_in;
      if (w_wrap) r_comm <= i_load ? w_in : r_pend;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_an    <= AN_OFF;
      r_num   <= '0;
      r_dp_n  <= DP_OFF;
      r_frame <= 1'b0;
    end else begin
      r_an    <= w_an_nxt;
      r_num   <= w_num_nxt;
      r_dp_n  <= w_dp_n_nxt;
      r_frame <= w_wrap;
    end
  end

  assign o_an    = r_an;
  assign o_num   = r_num;
  assign o_dp_n  = r_dp_n;
  assign o_frame = r_frame;

endmodule
